// File: rtl/uncache_axi_bridge_pkg.sv
// Shared definitions for the uncached-request to AXI3 bridge: FSM encoding and fixed AXI field values.
package uncache_axi_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_AR  = 3'd1,
      RD_R   = 3'd2,
      WR_AWW = 3'd3,
      WR_B   = 3'd4
   } state_t;

   localparam logic [3:0] AXI_LEN_SINGLE    = 4'd0;
   localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
   localparam logic [1:0] AXI_LOCK_NORMAL   = 2'b00;
   localparam logic [3:0] AXI_CACHE_DEFAULT = 4'd0;
   localparam logic [2:0] AXI_PROT_DEFAULT  = 3'd0;

   function automatic logic [2:0] axi_size(input logic [1:0] uc_size);
      return {1'b0, uc_size};
   endfunction

endpackage

// File: rtl/uncache_axi_bridge.sv
// Converts the store buffer's SRAM-like uncached request stream into single-beat AXI3 transactions,
// one outstanding at a time so stores and uncached loads stay in program order.
//
// state  | meaning
// IDLE   | waiting for uc_req; uc_addr_ok follows uc_req
// RD_AR  | read address presented, waiting for arready
// RD_R   | rready high, waiting for read data
// WR_AWW | write address and data presented, each dropped once handshaken
// WR_B   | bready high, waiting for write response
module uncache_axi_bridge
   import uncache_axi_bridge_pkg::*;
#(
   parameter int              ID_W  = 4,
   parameter logic [ID_W-1:0] RD_ID = ID_W'(1),
   parameter logic [ID_W-1:0] WR_ID = ID_W'(1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            uc_req,
   input  logic            uc_wr,
   input  logic [1:0]      uc_size,
   input  logic [31:0]     uc_addr,
   input  logic [31:0]     uc_wdata,
   input  logic [3:0]      uc_wstrb,
   output logic            uc_addr_ok,
   output logic            uc_data_ok,
   output logic [31:0]     uc_rdata,
   output logic [ID_W-1:0] axi_arid,
   output logic [31:0]     axi_araddr,
   output logic [3:0]      axi_arlen,
   output logic [2:0]      axi_arsize,
   output logic [1:0]      axi_arburst,
   output logic [1:0]      axi_arlock,
   output logic [3:0]      axi_arcache,
   output logic [2:0]      axi_arprot,
   output logic            axi_arvalid,
   input  logic            axi_arready,
   input  logic [ID_W-1:0] axi_rid,
   input  logic [31:0]     axi_rdata,
   input  logic [1:0]      axi_rresp,
   input  logic            axi_rlast,
   input  logic            axi_rvalid,
   output logic            axi_rready,
   output logic [ID_W-1:0] axi_awid,
   output logic [31:0]     axi_awaddr,
   output logic [3:0]      axi_awlen,
   output logic [2:0]      axi_awsize,
   output logic [1:0]      axi_awburst,
   output logic [1:0]      axi_awlock,
   output logic [3:0]      axi_awcache,
   output logic [2:0]      axi_awprot,
   output logic            axi_awvalid,
   input  logic            axi_awready,
   output logic [ID_W-1:0] axi_wid,
   output logic [31:0]     axi_wdata,
   output logic [3:0]      axi_wstrb,
   output logic            axi_wlast,
   output logic            axi_wvalid,
   input  logic            axi_wready,
   input  logic [ID_W-1:0] axi_bid,
   input  logic [1:0]      axi_bresp,
   input  logic            axi_bvalid,
   output logic            axi_bready
);

   state_t      state;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        aw_done;
   logic        w_done;
   logic        aw_hs;
   logic        w_hs;

   // Responses carry no information this bridge acts on.
   logic unused_resp;
   assign unused_resp = ^{axi_rid, axi_rresp, axi_rlast, axi_bid, axi_bresp};

   assign uc_addr_ok = (state == IDLE) && uc_req && !rst;
   assign aw_hs      = axi_awvalid && axi_awready;
   assign w_hs       = axi_wvalid && axi_wready;

   assign axi_arid    = RD_ID;
   assign axi_araddr  = addr_q;
   assign axi_arlen   = AXI_LEN_SINGLE;
   assign axi_arsize  = axi_size(size_q);
   assign axi_arburst = AXI_BURST_INCR;
   assign axi_arlock  = AXI_LOCK_NORMAL;
   assign axi_arcache = AXI_CACHE_DEFAULT;
   assign axi_arprot  = AXI_PROT_DEFAULT;

   assign axi_awid    = WR_ID;
   assign axi_awaddr  = addr_q;
   assign axi_awlen   = AXI_LEN_SINGLE;
   assign axi_awsize  = axi_size(size_q);
   assign axi_awburst = AXI_BURST_INCR;
   assign axi_awlock  = AXI_LOCK_NORMAL;
   assign axi_awcache = AXI_CACHE_DEFAULT;
   assign axi_awprot  = AXI_PROT_DEFAULT;

   assign axi_wid   = WR_ID;
   assign axi_wdata = wdata_q;
   assign axi_wstrb = wstrb_q;
   assign axi_wlast = 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         addr_q      <= '0;
         size_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         axi_arvalid <= 1'b0;
         axi_rready  <= 1'b0;
         axi_awvalid <= 1'b0;
         axi_wvalid  <= 1'b0;
         axi_bready  <= 1'b0;
         uc_data_ok  <= 1'b0;
         uc_rdata    <= '0;
      end else begin
         uc_data_ok <= 1'b0;
         unique case (state)
            IDLE: begin
               if (uc_req) begin
                  addr_q  <= uc_addr;
                  size_q  <= uc_size;
                  wdata_q <= uc_wdata;
                  wstrb_q <= uc_wstrb;
                  if (uc_wr) begin
                     axi_awvalid <= 1'b1;
                     axi_wvalid  <= 1'b1;
                     state       <= WR_AWW;
                  end else begin
                     axi_arvalid <= 1'b1;
                     state       <= RD_AR;
                  end
               end
            end
            RD_AR: begin
               if (axi_arready) begin
                  axi_arvalid <= 1'b0;
                  axi_rready  <= 1'b1;
                  state       <= RD_R;
               end
            end
            RD_R: begin
               if (axi_rvalid) begin
                  uc_rdata   <= axi_rdata;
                  uc_data_ok <= 1'b1;
                  axi_rready <= 1'b0;
                  state      <= IDLE;
               end
            end
            WR_AWW: begin
               if (aw_hs) begin
                  axi_awvalid <= 1'b0;
                  aw_done     <= 1'b1;
               end
               if (w_hs) begin
                  axi_wvalid <= 1'b0;
                  w_done     <= 1'b1;
               end
               // A handshake in this very cycle counts toward completion.
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  axi_bready <= 1'b1;
                  state      <= WR_B;
               end
            end
            WR_B: begin
               if (axi_bvalid) begin
                  axi_bready <= 1'b0;
                  uc_data_ok <= 1'b1;
                  aw_done    <= 1'b0;
                  w_done     <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Scoreboard bench for uncache_axi_bridge: a negedge AXI slave model with per-channel delays,
// a driver that queues expectations on accept, and a monitor that checks every uc_data_ok.
`timescale 1ns/1ps
module tb_uncache_axi_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uc_req = 1'b0, uc_wr = 1'b0;
   logic [1:0]  uc_size = '0;
   logic [31:0] uc_addr = '0, uc_wdata = '0;
   logic [3:0]  uc_wstrb = '0;
   logic        uc_addr_ok, uc_data_ok;
   logic [31:0] uc_rdata;
   logic [3:0]  axi_arid, axi_arlen, axi_arcache;
   logic [31:0] axi_araddr;
   logic [2:0]  axi_arsize, axi_arprot;
   logic [1:0]  axi_arburst, axi_arlock;
   logic        axi_arvalid, axi_arready = 1'b0;
   logic [3:0]  axi_rid = 4'd1;
   logic [31:0] axi_rdata = '0;
   logic [1:0]  axi_rresp = 2'b00;
   logic        axi_rlast = 1'b1, axi_rvalid = 1'b0, axi_rready;
   logic [3:0]  axi_awid, axi_awlen, axi_awcache;
   logic [31:0] axi_awaddr;
   logic [2:0]  axi_awsize, axi_awprot;
   logic [1:0]  axi_awburst, axi_awlock;
   logic        axi_awvalid, axi_awready = 1'b0;
   logic [3:0]  axi_wid, axi_wstrb;
   logic [31:0] axi_wdata;
   logic        axi_wlast, axi_wvalid, axi_wready = 1'b0;
   logic [3:0]  axi_bid = 4'd1;
   logic [1:0]  axi_bresp = 2'b00;
   logic        axi_bvalid = 1'b0, axi_bready;

   uncache_axi_bridge dut (
      .clk(clk), .rst(rst),
      .uc_req(uc_req), .uc_wr(uc_wr), .uc_size(uc_size), .uc_addr(uc_addr),
      .uc_wdata(uc_wdata), .uc_wstrb(uc_wstrb),
      .uc_addr_ok(uc_addr_ok), .uc_data_ok(uc_data_ok), .uc_rdata(uc_rdata),
      .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
      .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
      .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
      .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
      .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wid(axi_wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { bit rd; logic [31:0] rdata; int acc; int lat; } exp_t;
   typedef struct { logic [31:0] addr; logic [2:0] size; } ad_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; } wd_t;

   exp_t        exp_q[$];
   ad_t         ar_q[$];
   ad_t         aw_q[$];
   wd_t         w_q[$];
   logic [31:0] rd_q[$];

   int errors = 0, checks = 0;
   int outstanding = 0, accepts = 0, last_dok_cyc = -1;
   int ar_hs_n = 0, aw_hs_n = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
   endtask

   // AXI slave model: ready/valid decided at negedge, handshake happens at the following posedge.
   int  ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
   int  ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   bit  r_pend = 0, b_pend = 0, aw_seen = 0, w_seen = 0, stray_en = 0;
   bit  ar_wait = 0, aw_wait = 0, w_wait = 0, aw_prev = 0, w_prev = 0;
   logic [31:0] r_val = '0;

   always @(negedge clk) begin
      ad_t a;
      wd_t w;
      bit  aw_hs, w_hs;
      if (rst) begin
         r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
         ar_wait = 0; aw_wait = 0; w_wait = 0; aw_prev = 0; w_prev = 0;
         ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         axi_arready = 0; axi_rvalid = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
      end else begin
         if (ar_wait) chk("arvalid_held", axi_arvalid, 1);
         if (aw_wait) chk("awvalid_held", axi_awvalid, 1);
         if (w_wait)  chk("wvalid_held", axi_wvalid, 1);
         if (aw_prev) chk("awvalid_drops", axi_awvalid, 0);
         if (w_prev)  chk("wvalid_drops", axi_wvalid, 0);
         if (axi_bready) chk("bready_after_aw_w", {aw_seen, w_seen}, 2'b11);

         axi_rvalid = 0;
         if (r_pend) begin
            if (r_cnt >= r_delay) begin
               axi_rvalid = 1;
               axi_rdata  = r_val;
               if (axi_rready) r_pend = 0;
            end else r_cnt++;
         end else if (stray_en) begin
            axi_rvalid = 1;
            axi_rdata  = 32'hBAD0_BAD0;
            chk("stray_rvalid_ack", axi_rready, 0);
         end

         axi_bvalid = 0;
         if (b_pend) begin
            if (b_cnt >= b_delay) begin
               axi_bvalid = 1;
               if (axi_bready) begin
                  b_pend = 0; aw_seen = 0; w_seen = 0;
               end
            end else b_cnt++;
         end

         axi_arready = axi_arvalid && (ar_cnt >= ar_delay);
         ar_wait = axi_arvalid && !axi_arready;
         if (axi_arvalid) begin
            chk("ar_excl_aw_b", {axi_awvalid, axi_bready}, 2'b00);
            if (axi_arready) begin
               ar_hs_n++;
               ar_cnt = 0;
               if (ar_q.size() == 0) fail("ar_unexpected");
               else begin
                  a = ar_q.pop_front();
                  chk("ar_fields",
                      {axi_araddr, axi_arsize, axi_arlen, axi_arburst, axi_arlock, axi_arcache, axi_arprot, axi_arid},
                      {a.addr, a.size, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1});
               end
               r_val  = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
               r_pend = 1;
               r_cnt  = 0;
            end else ar_cnt++;
         end

         axi_awready = axi_awvalid && (aw_cnt >= aw_delay);
         aw_hs   = axi_awvalid && axi_awready;
         aw_wait = axi_awvalid && !axi_awready;
         if (axi_awvalid && !aw_hs) aw_cnt++;
         if (aw_hs) begin
            aw_hs_n++;
            aw_cnt  = 0;
            aw_seen = 1;
            if (aw_q.size() == 0) fail("aw_unexpected");
            else begin
               a = aw_q.pop_front();
               chk("aw_fields",
                   {axi_awaddr, axi_awsize, axi_awlen, axi_awburst, axi_awlock, axi_awcache, axi_awprot, axi_awid},
                   {a.addr, a.size, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1});
            end
         end

         axi_wready = axi_wvalid && (w_cnt >= w_delay);
         w_hs   = axi_wvalid && axi_wready;
         w_wait = axi_wvalid && !axi_wready;
         if (axi_wvalid && !w_hs) w_cnt++;
         if (w_hs) begin
            w_cnt  = 0;
            w_seen = 1;
            if (w_q.size() == 0) fail("w_unexpected");
            else begin
               w = w_q.pop_front();
               chk("w_fields", {axi_wdata, axi_wstrb, axi_wlast, axi_wid}, {w.data, w.strb, 1'b1, 4'd1});
            end
         end

         if ((aw_hs || w_hs) && aw_seen && w_seen) begin
            b_pend = 1;
            b_cnt  = 0;
         end
         aw_prev = aw_hs;
         w_prev  = w_hs;
      end
   end

   // Monitor: every uc_data_ok pops one expected completion.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && uc_data_ok) begin
         if (exp_q.size() == 0) fail("spurious_data_ok");
         else begin
            e = exp_q.pop_front();
            if (e.lat != 0) chk("data_ok_latency", cyc - e.acc, e.lat);
            if (e.rd) chk("uc_rdata", uc_rdata, e.rdata);
            outstanding--;
            last_dok_cyc = cyc;
         end
      end
   end

   task automatic issue(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] rdata, input int lat, input bit b2b);
      bit   acc = 0;
      int   n = 0;
      exp_t e;
      ad_t  a;
      wd_t  w;
      @(negedge clk); #1;
      uc_req = 1; uc_wr = wr; uc_size = size; uc_addr = addr; uc_wdata = wdata; uc_wstrb = wstrb;
      while (!acc && n < 200) begin
         #1;
         chk("addr_ok", uc_addr_ok, outstanding == 0);
         if (uc_addr_ok) begin
            acc = 1;
            accepts++;
            outstanding++;
            if (b2b) chk("b2b_accept_cycle", cyc, last_dok_cyc);
            e.rd = !wr; e.rdata = rdata; e.acc = cyc; e.lat = lat;
            exp_q.push_back(e);
            a.addr = addr; a.size = {1'b0, size};
            if (wr) begin
               aw_q.push_back(a);
               w.data = wdata; w.strb = wstrb;
               w_q.push_back(w);
            end else begin
               ar_q.push_back(a);
               rd_q.push_back(rdata);
            end
         end else begin
            n++;
            @(negedge clk); #1;
         end
      end
      if (!acc) fail("accept_timeout");
      @(posedge clk); #1;
      uc_req = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (outstanding != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (outstanding != 0) fail("idle_timeout");
      @(negedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      uc_req = 1;
      #2;
      chk("reset_outputs",
          {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready, uc_data_ok, uc_addr_ok}, 7'b0);
      chk("reset_rdata", uc_rdata, 32'h0);
      uc_req = 0;
      @(negedge clk); #2;
      rst = 0;

      // 1: word read, slave always ready
      issue(0, 2'd2, 32'h1FAF_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 3, 0);
      wait_idle();

      // 2: byte write with awready held off for 3 cycles
      aw_delay = 3;
      issue(1, 2'd0, 32'h1FAF_F000, 32'h0000_5A00, 4'b0010, 32'h0, 6, 0);
      wait_idle();
      aw_delay = 0;
      chk("rdata_hold", uc_rdata, 32'hDEAD_BEEF);

      // 3: write, then a read accepted in the write's uc_data_ok cycle
      issue(1, 2'd2, 32'h1FAF_1004, 32'h1234_5678, 4'hF, 32'h0, 3, 0);
      issue(0, 2'd1, 32'h1FAF_2002, 32'h0, 4'h0, 32'h0000_CAFE, 3, 1);
      wait_idle();

      // 4: slow slave, request held high while busy
      ar_delay = 1; r_delay = 2;
      issue(0, 2'd0, 32'h1FAF_3001, 32'h0, 4'h0, 32'h1122_3344, 6, 0);
      issue(0, 2'd2, 32'h1FAF_3008, 32'h0, 4'h0, 32'h5566_7788, 6, 1);
      wait_idle();
      ar_delay = 0; r_delay = 0;
      w_delay = 2;
      issue(1, 2'd1, 32'h1FAF_4002, 32'hBEEF_0000, 4'b1100, 32'h0, 5, 0);
      wait_idle();
      w_delay = 0;
      stray_en = 1;
      repeat (3) @(negedge clk);
      #1 stray_en = 0;

      // 5: reset while waiting for read data
      r_delay = 5;
      issue(0, 2'd2, 32'h1FAF_5000, 32'h0, 4'h0, 32'h9999_9999, 0, 0);
      n = 0;
      while (axi_rready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reached_rd_r", axi_rready, 1);
      #2 rst = 1;
      #1;
      chk("rst_outputs", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready, uc_data_ok}, 6'b0);
      exp_q.delete();
      rd_q.delete();
      outstanding = 0;
      @(negedge clk);
      @(negedge clk); #2;
      rst = 0;
      r_delay = 0;
      chk("rst_rdata", uc_rdata, 32'h0);
      issue(0, 2'd2, 32'h1FAF_6000, 32'h0, 4'h0, 32'h0BAD_F00D, 3, 0);
      wait_idle();
      repeat (4) @(negedge clk);

      chk("queues_empty", exp_q.size() + ar_q.size() + aw_q.size() + w_q.size(), 0);
      chk("one_axi_txn_per_accept", ar_hs_n + aw_hs_n, accepts);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
